// File: rtl/inst_execute_if.sv
// Decode-to-execute bundle: operands in, registered results out.
// master = decode/memory side, slave = execute stage.
interface inst_execute_if;
    logic        VALID_IN;
    logic [15:0] REG_A;
    logic [15:0] REG_B;
    logic [15:0] IMM;
    logic [15:0] NPC_IN;
    logic [4:0]  OPCD;
    logic [4:0]  ADDR_REG;
    logic        OPT_BIT;
    logic        BUSY;
    logic        VALID_OUT;
    logic [15:0] EXE_OUT;
    logic [15:0] STORE_DATA;
    logic [4:0]  RD_OUT;
    logic [4:0]  OPCD_OUT;
    logic        COND_OUT;
    logic        BRANCH_TAKEN;
    logic [15:0] BRANCH_TARGET;
    logic [2:0]  ESTADO;

    modport master (
        output VALID_IN, REG_A, REG_B, IMM, NPC_IN,
        output OPCD, ADDR_REG, OPT_BIT,
        input  BUSY, VALID_OUT, EXE_OUT, STORE_DATA,
        input  RD_OUT, OPCD_OUT, COND_OUT,
        input  BRANCH_TAKEN, BRANCH_TARGET, ESTADO
    );

    modport slave (
        input  VALID_IN, REG_A, REG_B, IMM, NPC_IN,
        input  OPCD, ADDR_REG, OPT_BIT,
        output BUSY, VALID_OUT, EXE_OUT, STORE_DATA,
        output RD_OUT, OPCD_OUT, COND_OUT,
        output BRANCH_TAKEN, BRANCH_TARGET, ESTADO
    );
endinterface

// File: rtl/inst_execute.sv
// Execute stage: single-cycle ALU, shift-add multiplier, branch resolve.
// A taken branch spends one FLUSH cycle to drop the wrong-path slot.
module inst_execute (
    input  logic           CLK,
    input  logic           RST,
    inst_execute_if.slave  ex
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_NOT = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_SLT = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;
    localparam logic [4:0] OP_LW  = 5'd11;
    localparam logic [4:0] OP_SW  = 5'd12;
    localparam logic [4:0] OP_BEQ = 5'd13;
    localparam logic [4:0] OP_BNE = 5'd14;
    localparam logic [4:0] OP_JMP = 5'd15;
    localparam logic [4:0] OP_LI  = 5'd16;

    logic [2:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [15:0] exe_q, exe_d;
    logic [15:0] store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  opcd_q, opcd_d;
    logic        cond_q, cond_d;
    logic        taken_q, taken_d;
    logic [15:0] target_q, target_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [15:0] op2;
    logic [15:0] alu_res;
    logic [15:0] alu_store;
    logic        alu_cond;
    logic        alu_taken;
    logic [15:0] alu_target;
    logic [15:0] mul_sum;

    assign op2 = ex.OPT_BIT ? ex.IMM : ex.REG_B;
    assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : 16'd0);

    always_comb begin
        alu_res    = 16'd0;
        alu_store  = 16'd0;
        alu_cond   = 1'b0;
        alu_taken  = 1'b0;
        alu_target = 16'd0;
        case (ex.OPCD)
            OP_NOP: ;
            OP_ADD: begin
                alu_res  = ex.REG_A + op2;
                alu_cond = 1'b1;
            end
            OP_SUB: begin
                alu_res  = ex.REG_A - op2;
                alu_cond = 1'b1;
            end
            OP_AND: begin
                alu_res  = ex.REG_A & op2;
                alu_cond = 1'b1;
            end
            OP_OR: begin
                alu_res  = ex.REG_A | op2;
                alu_cond = 1'b1;
            end
            OP_XOR: begin
                alu_res  = ex.REG_A ^ op2;
                alu_cond = 1'b1;
            end
            OP_NOT: begin
                alu_res  = ~ex.REG_A;
                alu_cond = 1'b1;
            end
            OP_SHL: begin
                alu_res  = ex.REG_A << op2[3:0];
                alu_cond = 1'b1;
            end
            OP_SHR: begin
                alu_res  = ex.REG_A >> op2[3:0];
                alu_cond = 1'b1;
            end
            OP_SLT: begin
                alu_res  = {15'd0, $signed(ex.REG_A) < $signed(op2)};
                alu_cond = 1'b1;
            end
            OP_MUL: alu_cond = 1'b1;
            OP_LW: begin
                alu_res  = ex.REG_A + ex.IMM;
                alu_cond = 1'b1;
            end
            OP_SW: begin
                alu_res   = ex.REG_A + ex.IMM;
                alu_store = ex.REG_B;
            end
            OP_BEQ: begin
                alu_taken  = (ex.REG_A == ex.REG_B);
                alu_target = ex.NPC_IN + ex.IMM;
            end
            OP_BNE: begin
                alu_taken  = (ex.REG_A != ex.REG_B);
                alu_target = ex.NPC_IN + ex.IMM;
            end
            OP_JMP: begin
                alu_taken  = 1'b1;
                alu_target = ex.IMM;
            end
            OP_LI: begin
                alu_res  = ex.IMM;
                alu_cond = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        exe_d    = exe_q;
        store_d  = store_q;
        rd_d     = rd_q;
        opcd_d   = opcd_q;
        cond_d   = cond_q;
        taken_d  = taken_q;
        target_d = target_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (ex.VALID_IN) begin
                    rd_d   = ex.ADDR_REG;
                    opcd_d = ex.OPCD;
                    if (ex.OPCD == OP_MUL) begin
                        mcand_d  = ex.REG_A;
                        mplier_d = op2;
                        prod_d   = 16'd0;
                        cnt_d    = 5'd0;
                        state_d  = S_MUL;
                    end else begin
                        valid_d  = 1'b1;
                        exe_d    = alu_res;
                        store_d  = alu_store;
                        cond_d   = alu_cond;
                        taken_d  = alu_taken;
                        target_d = alu_target;
                        if (alu_taken)
                            state_d = S_FLUSH;
                    end
                end
            end
            (state_q == S_MUL): begin
                prod_d   = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Sixteenth iteration publishes the product directly.
                if (cnt_q == 5'd15) begin
                    valid_d  = 1'b1;
                    exe_d    = mul_sum;
                    store_d  = 16'd0;
                    cond_d   = 1'b1;
                    taken_d  = 1'b0;
                    target_d = 16'd0;
                    state_d  = S_IDLE;
                end
            end
            (state_q == S_FLUSH): state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            exe_q    <= 16'd0;
            store_q  <= 16'd0;
            rd_q     <= 5'd0;
            opcd_q   <= 5'd0;
            cond_q   <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= 16'd0;
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            prod_q   <= 16'd0;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            exe_q    <= exe_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            opcd_q   <= opcd_d;
            cond_q   <= cond_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex.BUSY          = (state_q == S_MUL);
    assign ex.VALID_OUT     = valid_q;
    assign ex.EXE_OUT       = exe_q;
    assign ex.STORE_DATA    = store_q;
    assign ex.RD_OUT        = rd_q;
    assign ex.OPCD_OUT      = opcd_q;
    assign ex.COND_OUT      = cond_q;
    assign ex.BRANCH_TAKEN  = taken_q;
    assign ex.BRANCH_TARGET = target_q;
    assign ex.ESTADO        = state_q;

endmodule

// File: tb/tb_inst_execute.sv
// Directed bench for inst_execute: ALU, MUL, branch flush, memory, reset.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_inst_execute;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    inst_execute_if bus ();

    inst_execute dut (
        .CLK (CLK),
        .RST (RST),
        .ex  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        bus.VALID_IN = 1'b0;
        bus.REG_A    = 16'd0;
        bus.REG_B    = 16'd0;
        bus.IMM      = 16'd0;
        bus.NPC_IN   = 16'd0;
        bus.OPCD     = 5'd0;
        bus.ADDR_REG = 5'd0;
        bus.OPT_BIT  = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm,
                         input logic [15:0] npc, input logic [4:0] rd,
                         input logic opt);
        bus.VALID_IN = 1'b1;
        bus.OPCD     = op;
        bus.REG_A    = a;
        bus.REG_B    = b;
        bus.IMM      = imm;
        bus.NPC_IN   = npc;
        bus.ADDR_REG = rd;
        bus.OPT_BIT  = opt;
        @(posedge CLK);
        #1;
        bus.VALID_IN = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.VALID_IN = 1'($urandom);
            bus.REG_A    = 16'($urandom);
            bus.REG_B    = 16'($urandom);
            bus.IMM      = 16'($urandom);
            bus.NPC_IN   = 16'($urandom);
            bus.OPCD     = 5'($urandom);
            bus.ADDR_REG = 5'($urandom);
            bus.OPT_BIT  = 1'($urandom);
            idle_cycle();
        end
        total++;
        if ({bus.VALID_OUT, bus.EXE_OUT, bus.STORE_DATA, bus.RD_OUT,
             bus.OPCD_OUT, bus.COND_OUT, bus.BRANCH_TAKEN,
             bus.BRANCH_TARGET} !== 62'd0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%0d exe=%0h st=%0h rd=%0d taken=%0d tgt=%0h exp all 0",
                     bus.VALID_OUT, bus.EXE_OUT, bus.STORE_DATA,
                     bus.RD_OUT, bus.BRANCH_TAKEN, bus.BRANCH_TARGET);
        end
        total++;
        if (bus.ESTADO !== 3'd0 || bus.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got estado=%0d busy=%0d exp 0 0",
                     bus.ESTADO, bus.BUSY);
        end
        clear_inputs();
        RST = 1'b1;
        idle_cycle();
        total++;
        if (bus.VALID_OUT !== 1'b0 || bus.EXE_OUT !== 16'd0) begin
            bad++;
            $display("FAIL reset_release got valid=%0d exe=%0h exp 0 0",
                     bus.VALID_OUT, bus.EXE_OUT);
        end
    endtask

    task automatic test_alu();
        drive(5'd1, 16'd5, 16'd7, 16'd0, 16'd0, 5'd3, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'd12 || bus.RD_OUT !== 5'd3 ||
            bus.COND_OUT !== 1'b1 || bus.VALID_OUT !== 1'b1) begin
            bad++;
            $display("FAIL add got exe=%0d rd=%0d cond=%0d valid=%0d exp 12 3 1 1",
                     bus.EXE_OUT, bus.RD_OUT, bus.COND_OUT, bus.VALID_OUT);
        end
        idle_cycle();
        total++;
        if (bus.VALID_OUT !== 1'b0 || bus.EXE_OUT !== 16'd12) begin
            bad++;
            $display("FAIL add_hold got valid=%0d exe=%0d exp 0 12",
                     bus.VALID_OUT, bus.EXE_OUT);
        end
        drive(5'd2, 16'd5, 16'd7, 16'd0, 16'd0, 5'd4, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'hFFFE || bus.VALID_OUT !== 1'b1) begin
            bad++;
            $display("FAIL sub got exe=%0h valid=%0d exp fffe 1",
                     bus.EXE_OUT, bus.VALID_OUT);
        end
        drive(5'd9, 16'hFFFE, 16'd1, 16'd0, 16'd0, 5'd5, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'd1 || bus.COND_OUT !== 1'b1) begin
            bad++;
            $display("FAIL slt got exe=%0h cond=%0d exp 1 1",
                     bus.EXE_OUT, bus.COND_OUT);
        end
        drive(5'd7, 16'h0003, 16'd0, 16'h0014, 16'd0, 5'd6, 1'b1);
        total++;
        if (bus.EXE_OUT !== 16'h0030) begin
            bad++;
            $display("FAIL shl_imm got exe=%0h exp 0030", bus.EXE_OUT);
        end
        drive(5'd8, 16'h8000, 16'd15, 16'd0, 16'd0, 5'd6, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'h0001) begin
            bad++;
            $display("FAIL shr got exe=%0h exp 0001", bus.EXE_OUT);
        end
        drive(5'd5, 16'hF0F0, 16'h0FF0, 16'd0, 16'd0, 5'd6, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'hFF00) begin
            bad++;
            $display("FAIL xor got exe=%0h exp ff00", bus.EXE_OUT);
        end
        drive(5'd16, 16'd0, 16'd0, 16'hBEEF, 16'd0, 5'd9, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'hBEEF || bus.COND_OUT !== 1'b1) begin
            bad++;
            $display("FAIL li got exe=%0h cond=%0d exp beef 1",
                     bus.EXE_OUT, bus.COND_OUT);
        end
        idle_cycle();
    endtask

    task automatic test_mul();
        int pulses;
        pulses = 0;
        drive(5'd10, 16'd300, 16'd0, 16'd250, 16'd0, 5'd8, 1'b1);
        total++;
        if (bus.BUSY !== 1'b1 || bus.ESTADO !== 3'd1 ||
            bus.VALID_OUT !== 1'b0) begin
            bad++;
            $display("FAIL mul_start got busy=%0d estado=%0d valid=%0d exp 1 1 0",
                     bus.BUSY, bus.ESTADO, bus.VALID_OUT);
        end
        for (int i = 1; i < 16; i++) begin
            if (i == 5) begin
                bus.VALID_IN = 1'b1;
                bus.OPCD     = 5'd1;
                bus.REG_A    = 16'd1;
                bus.REG_B    = 16'd1;
                bus.OPT_BIT  = 1'b0;
            end
            if (i == 7)
                clear_inputs();
            idle_cycle();
            if (bus.VALID_OUT === 1'b1)
                pulses++;
            total++;
            if (bus.BUSY !== 1'b1) begin
                bad++;
                $display("FAIL mul_busy cycle %0d got busy=%0d exp 1",
                         i, bus.BUSY);
            end
        end
        idle_cycle();
        total++;
        if (bus.VALID_OUT !== 1'b1 || bus.EXE_OUT !== 16'd9464 ||
            bus.COND_OUT !== 1'b1 || bus.RD_OUT !== 5'd8) begin
            bad++;
            $display("FAIL mul_result got valid=%0d exe=%0d cond=%0d rd=%0d exp 1 9464 1 8",
                     bus.VALID_OUT, bus.EXE_OUT, bus.COND_OUT, bus.RD_OUT);
        end
        total++;
        if (bus.BUSY !== 1'b0 || bus.ESTADO !== 3'd0) begin
            bad++;
            $display("FAIL mul_done got busy=%0d estado=%0d exp 0 0",
                     bus.BUSY, bus.ESTADO);
        end
        idle_cycle();
        if (bus.VALID_OUT === 1'b1)
            pulses++;
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL mul_extra_valid got %0d exp 0", pulses);
        end
    endtask

    task automatic test_branch();
        drive(5'd13, 16'd9, 16'd9, 16'd20, 16'd500, 5'd0, 1'b0);
        total++;
        if (bus.BRANCH_TAKEN !== 1'b1 || bus.BRANCH_TARGET !== 16'd520 ||
            bus.ESTADO !== 3'd2 || bus.VALID_OUT !== 1'b1 ||
            bus.COND_OUT !== 1'b0) begin
            bad++;
            $display("FAIL beq got taken=%0d tgt=%0d estado=%0d valid=%0d cond=%0d exp 1 520 2 1 0",
                     bus.BRANCH_TAKEN, bus.BRANCH_TARGET, bus.ESTADO,
                     bus.VALID_OUT, bus.COND_OUT);
        end
        drive(5'd1, 16'd1, 16'd1, 16'd0, 16'd0, 5'd7, 1'b0);
        total++;
        if (bus.VALID_OUT !== 1'b0 || bus.ESTADO !== 3'd0) begin
            bad++;
            $display("FAIL flush_drop got valid=%0d estado=%0d exp 0 0",
                     bus.VALID_OUT, bus.ESTADO);
        end
        idle_cycle();
        total++;
        if (bus.VALID_OUT !== 1'b0) begin
            bad++;
            $display("FAIL flush_late got valid=%0d exp 0", bus.VALID_OUT);
        end
        drive(5'd14, 16'd9, 16'd9, 16'd20, 16'd500, 5'd0, 1'b0);
        total++;
        if (bus.BRANCH_TAKEN !== 1'b0 || bus.ESTADO !== 3'd0 ||
            bus.VALID_OUT !== 1'b1) begin
            bad++;
            $display("FAIL bne got taken=%0d estado=%0d valid=%0d exp 0 0 1",
                     bus.BRANCH_TAKEN, bus.ESTADO, bus.VALID_OUT);
        end
        drive(5'd1, 16'd2, 16'd3, 16'd0, 16'd0, 5'd7, 1'b0);
        total++;
        if (bus.VALID_OUT !== 1'b1 || bus.EXE_OUT !== 16'd5 ||
            bus.BRANCH_TAKEN !== 1'b0 || bus.BRANCH_TARGET !== 16'd0) begin
            bad++;
            $display("FAIL back_to_back got valid=%0d exe=%0d taken=%0d tgt=%0h exp 1 5 0 0",
                     bus.VALID_OUT, bus.EXE_OUT, bus.BRANCH_TAKEN,
                     bus.BRANCH_TARGET);
        end
        drive(5'd15, 16'd0, 16'd0, 16'h1234, 16'd77, 5'd0, 1'b0);
        total++;
        if (bus.BRANCH_TAKEN !== 1'b1 || bus.BRANCH_TARGET !== 16'h1234 ||
            bus.ESTADO !== 3'd2) begin
            bad++;
            $display("FAIL jmp got taken=%0d tgt=%0h estado=%0d exp 1 1234 2",
                     bus.BRANCH_TAKEN, bus.BRANCH_TARGET, bus.ESTADO);
        end
        idle_cycle();
    endtask

    task automatic test_memory();
        drive(5'd12, 16'd10, 16'd27, 16'd4, 16'd0, 5'd2, 1'b1);
        total++;
        if (bus.EXE_OUT !== 16'd14 || bus.STORE_DATA !== 16'd27 ||
            bus.COND_OUT !== 1'b0 || bus.OPCD_OUT !== 5'd12) begin
            bad++;
            $display("FAIL sw got exe=%0d st=%0d cond=%0d op=%0d exp 14 27 0 12",
                     bus.EXE_OUT, bus.STORE_DATA, bus.COND_OUT,
                     bus.OPCD_OUT);
        end
        drive(5'd11, 16'd10, 16'd27, 16'd4, 16'd0, 5'd2, 1'b0);
        total++;
        if (bus.EXE_OUT !== 16'd14 || bus.COND_OUT !== 1'b1 ||
            bus.VALID_OUT !== 1'b1) begin
            bad++;
            $display("FAIL lw got exe=%0d cond=%0d valid=%0d exp 14 1 1",
                     bus.EXE_OUT, bus.COND_OUT, bus.VALID_OUT);
        end
    endtask

    task automatic test_nop();
        drive(5'd31, 16'd55, 16'd66, 16'd77, 16'd0, 5'd1, 1'b0);
        total++;
        if (bus.VALID_OUT !== 1'b1 || bus.COND_OUT !== 1'b0 ||
            bus.EXE_OUT !== 16'd0 || bus.BRANCH_TAKEN !== 1'b0) begin
            bad++;
            $display("FAIL illegal got valid=%0d cond=%0d exe=%0h taken=%0d exp 1 0 0 0",
                     bus.VALID_OUT, bus.COND_OUT, bus.EXE_OUT,
                     bus.BRANCH_TAKEN);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        pulses = 0;
        drive(5'd10, 16'd3, 16'd4, 16'd0, 16'd0, 5'd2, 1'b0);
        for (int i = 0; i < 5; i++)
            idle_cycle();
        RST = 1'b0;
        #1;
        total++;
        if (bus.ESTADO !== 3'd0 || bus.BUSY !== 1'b0 ||
            bus.VALID_OUT !== 1'b0 || bus.EXE_OUT !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_mul got estado=%0d busy=%0d valid=%0d exe=%0h exp 0 0 0 0",
                     bus.ESTADO, bus.BUSY, bus.VALID_OUT, bus.EXE_OUT);
        end
        #1;
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle_cycle();
            if (bus.VALID_OUT === 1'b1 || bus.ESTADO !== 3'd0)
                pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_valid got %0d cycles active exp 0",
                     pulses);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        test_reset();
        test_alu();
        test_mul();
        test_branch();
        test_memory();
        test_nop();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_execute.md
# inst_execute

Execute stage of the 16-bit pipelined processor, directly downstream of the instruction-decode stage. It consumes the decoded operands (REG_A, REG_B, IMM, NPC, OPCD, ADDR_REG, OPT_BIT) and produces the ALU or effective-address result, store data, branch resolution and write-back control for the memory-access stage. Single-cycle ops complete in one clock. MUL runs a 16-iteration shift-add sequence and stalls the decode stage while it runs. A taken branch squashes the one wrong-path instruction behind it.

## Interface
Parameters:
- none (data 16 bits, register address 5 bits, opcode 5 bits, all fixed)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-low
- VALID_IN  in  1  decode presents a valid instruction this cycle
- REG_A  in  16  operand A
- REG_B  in  16  operand B; also store data
- IMM  in  16  sign-extended immediate
- NPC_IN  in  16  next PC of this instruction
- OPCD  in  5  opcode
- ADDR_REG  in  5  destination register
- OPT_BIT  in  1  second operand select: 0 = REG_B, 1 = IMM
- BUSY  out  1  combinational; high while ESTADO = MUL; decode holds its inputs
- VALID_OUT  out  1  registered results are valid this cycle
- EXE_OUT  out  16  ALU result or effective address
- STORE_DATA  out  16  REG_B captured for SW
- RD_OUT  out  5  destination register
- OPCD_OUT  out  5  opcode passed on to memory stage
- COND_OUT  out  1  result is to be written back
- BRANCH_TAKEN  out  1  taken branch/jump, valid with VALID_OUT
- BRANCH_TARGET  out  16  target PC
- ESTADO  out  3  state: 0 IDLE, 1 MUL, 2 FLUSH

## Operation
- OP2 = OPT_BIT ? IMM : REG_B. All arithmetic is modulo 2^16.
- Opcodes and results (EXE_OUT unless stated):
- 0 NOP: EXE_OUT=0, COND_OUT=0.
- 1 ADD: A+OP2. 2 SUB: A-OP2. 3 AND. 4 OR. 5 XOR. 6 NOT: ~A.
- 7 SHL: A<<OP2[3:0]. 8 SHR: logical A>>OP2[3:0].
- 9 SLT: signed A<OP2 gives 1, otherwise 0.
- 10 MUL: low 16 bits of A*OP2, multi-cycle.
- 11 LW: A+IMM; COND_OUT=1.
- 12 SW: A+IMM; STORE_DATA=REG_B; COND_OUT=0.
- 13 BEQ: taken if A==REG_B. 14 BNE: taken if A!=REG_B. For both: BRANCH_TARGET=NPC_IN+IMM, COND_OUT=0.
- 15 JMP: always taken; BRANCH_TARGET=IMM; COND_OUT=0.
- 16 LI: IMM.
- 17–31: behave as NOP. VALID_OUT still pulses.
- COND_OUT=1 for opcodes 1–11 and 16.
- States:
  - IDLE: on VALID_IN, single-cycle op registers all outputs and VALID_OUT=1. MUL captures A, OP2, RD and OPCD, clears the product and counter, and goes to MUL with VALID_OUT=0. A taken branch goes to FLUSH. VALID_IN=0 gives VALID_OUT=0; the data outputs hold.
  - MUL: each edge does one iteration: if multiplier[0], product += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++. VALID_IN is ignored. The edge doing iteration 16 (cnt 15 to 16) loads EXE_OUT=product, VALID_OUT=1, COND_OUT=1 and returns to IDLE.
  - FLUSH: lasts one cycle. VALID_IN is ignored and the instruction is discarded. VALID_OUT=0. Goes to IDLE.
- BRANCH_TAKEN and BRANCH_TARGET are registered with their instruction and are zero on every other VALID_OUT.

## Timing
- Reset (RST=0), effective immediately and asynchronously: all outputs 0 and ESTADO=0. An in-progress MUL is aborted with no VALID_OUT. Decode resumes on the first edge after RST=1.
- Single-cycle op: sampled at edge k, VALID_OUT high for cycle k..k+1 (latency 1).
- MUL: sampled at edge k. BUSY is high from edge k to edge k+16. Result and VALID_OUT appear at edge k+16. A new VALID_IN is accepted at edge k+17 at the earliest.
- Taken branch at edge k: ESTADO=2 during cycle k..k+1, so the instruction presented at edge k+1 is dropped. The next accepted instruction is at edge k+2.
- An untaken branch does not enter FLUSH.
- VALID_OUT lasts exactly one cycle per accepted instruction.

## Test plan
- Reset: hold RST=0 with random inputs, then release. All outputs are 0 and ESTADO=0. Assert RST=0 mid-MUL: ESTADO goes to 0 immediately and no VALID_OUT is produced.
- ALU: ADD A=5, B=7, OPT_BIT=0, RD=3. Next edge gives EXE_OUT=12, RD_OUT=3, COND_OUT=1, VALID_OUT=1. SUB 5-7 gives 16'hFFFE. SLT 0xFFFE vs 1 gives 1.
- MUL: A=300, OPT_BIT=1, IMM=250. BUSY is high for 16 cycles. EXE_OUT=75000 mod 65536=9464, VALID_OUT is one pulse, and a VALID_IN pulse during BUSY is ignored.
- Branch: BEQ A=B=9, NPC_IN=500, IMM=20 gives BRANCH_TAKEN=1, BRANCH_TARGET=520, ESTADO=2 for one cycle, and the following ADD is dropped. BNE with the same operands is not taken, produces no flush, and the next op is accepted.
- Memory: SW with A=10, IMM=4, REG_B=27 gives EXE_OUT=14, STORE_DATA=27, COND_OUT=0. LW with the same operands gives EXE_OUT=14, COND_OUT=1.
- Illegal/NOP: OPCD=31 gives VALID_OUT=1, COND_OUT=0, EXE_OUT=0, BRANCH_TAKEN=0.
